// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader.
package loader_pkg;

  // Loader sequencing states; ST_CSUM is only reachable with LOADER_CHECKSUM_EN.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_CSUM,
    ST_DRAIN,
    ST_END,
    ST_DONE
  } loader_state_t;

  localparam int unsigned HDR_BYTES  = 4;
  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/byte_word_assembler.sv
// Shifts received bytes MSB-first into a 32-bit word and flags the byte
// that completes each word. The completed word is presented combinationally
// in the same cycle as its last byte.
module byte_word_assembler
  import loader_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_done
);

  localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);

  logic [23:0] r_shift;
  logic [1:0]  r_idx;

  // Shift register and byte index; index wraps after the last byte of a word.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shift <= '0;
      r_idx   <= '0;
    end else if (i_byte_valid) begin
      r_shift <= {r_shift[15:0], i_byte};
      r_idx   <= (r_idx == LAST_IDX) ? '0 : r_idx + 2'd1;
    end
  end

  assign o_word      = {r_shift, i_byte};
  assign o_word_done = i_byte_valid && (r_idx == LAST_IDX);

endmodule

// File: rtl/program_loader_ctrl.sv
// Program loader controller: turns a UART byte stream (header N, then N
// big-endian words) into fetch-stage loader events with a minimum gap
// between start, each toggle of input_valid, and end.
// Optional feature macro: LOADER_CHECKSUM_EN (4-byte sum trailer check).
module program_loader_ctrl
  import loader_pkg::*;
#(
  parameter int unsigned INST_MEM_WIDTH = 2,
  parameter int unsigned TOGGLE_GAP     = 4
) (
  input  logic                    CLK,
  input  logic                    reset,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic [31:0]             input_data,
  output logic                    input_valid,
  output logic                    input_start,
  output logic                    input_end,
  output logic                    busy,
  output logic                    done,
  output logic [INST_MEM_WIDTH:0] words_loaded,
  output logic                    size_err,
  output logic                    overrun_err,
  output logic                    checksum_err
);

  localparam logic [32:0]             CAPACITY = 33'd1 << INST_MEM_WIDTH;
  localparam logic [3:0]              GAP_LOAD = 4'(TOGGLE_GAP);
  localparam logic [INST_MEM_WIDTH:0] ONE_W    = (INST_MEM_WIDTH + 1)'(1);

  loader_state_t r_state;
  loader_state_t w_next;

  logic [3:0]              r_gap;
  logic [31:0]             r_n;
  logic [31:0]             r_rx_cnt;
  logic [31:0]             r_buf;
  logic                    r_buf_full;
  logic [31:0]             r_data;
  logic                    r_valid;
  logic                    r_start;
  logic [INST_MEM_WIDTH:0] r_words;
  logic                    r_size_err;
  logic                    r_ovr_err;

  logic [31:0] w_word;
  logic        w_word_done;
  logic        w_accept;
  logic        w_emit;
  logic        w_data_word;
  logic        w_last_word;
  logic        w_emittable;
  logic        w_gap_load;
  logic        w_to_end;

  assign w_accept = rx_valid && ((r_state == ST_IDLE) || (r_state == ST_HDR) ||
                                 (r_state == ST_DATA) || (r_state == ST_CSUM));

  byte_word_assembler u_asm (
    .i_clk        (CLK),
    .i_rst        (reset),
    .i_byte_valid (w_accept),
    .i_byte       (rx_data),
    .o_word       (w_word),
    .o_word_done  (w_word_done)
  );

  assign w_emit      = r_buf_full && (r_gap == '0);
  assign w_data_word = w_word_done && (r_state == ST_DATA);
  assign w_last_word = w_data_word && ((r_rx_cnt + 32'd1) == r_n);
  assign w_emittable = ({1'b0, r_rx_cnt} < CAPACITY);
  assign w_to_end    = (r_state == ST_DRAIN) && !r_buf_full && (r_gap == '0);
  assign w_gap_load  = ((r_state == ST_IDLE) && rx_valid) || w_emit || w_to_end;

  // State register.
  always_ff @(posedge CLK) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    w_next    = r_state;
    busy      = 1'b0;
    done      = 1'b0;
    input_end = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (rx_valid) w_next = ST_HDR;
      end
      ST_HDR: begin
        busy = 1'b1;
        if (w_word_done) w_next = (w_word == '0) ? ST_DRAIN : ST_DATA;
      end
      ST_DATA: begin
        busy = 1'b1;
`ifdef LOADER_CHECKSUM_EN
        if (w_last_word) w_next = ST_CSUM;
`else
        if (w_last_word) w_next = ST_DRAIN;
`endif
      end
      ST_CSUM: begin
        busy = 1'b1;
        if (w_word_done) w_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (w_to_end) w_next = ST_END;
      end
      ST_END: begin
        input_end = 1'b1;
        w_next    = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Gap counter: reloads on every loader event, otherwise counts down to 0.
  always_ff @(posedge CLK) begin
    if (reset)           r_gap <= '0;
    else if (w_gap_load) r_gap <= GAP_LOAD;
    else if (r_gap != '0) r_gap <= r_gap - 4'd1;
  end

  // Start pulse follows the first accepted byte by one cycle.
  always_ff @(posedge CLK) begin
    if (reset) r_start <= 1'b0;
    else       r_start <= (r_state == ST_IDLE) && rx_valid;
  end

  // Header capture, received-word counter and capacity check.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_n        <= '0;
      r_rx_cnt   <= '0;
      r_size_err <= 1'b0;
    end else begin
      if ((r_state == ST_HDR) && w_word_done) begin
        r_n <= w_word;
        if ({1'b0, w_word} > CAPACITY) r_size_err <= 1'b1;
      end
      if (w_data_word) r_rx_cnt <= r_rx_cnt + 32'd1;
    end
  end

  // Pending buffer: a completed word may refill it in the same cycle it is
  // emitted; a completion against a full, non-emitting buffer is dropped.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_buf      <= '0;
      r_buf_full <= 1'b0;
      r_ovr_err  <= 1'b0;
    end else begin
      if (w_data_word && w_emittable && (!r_buf_full || w_emit)) begin
        r_buf      <= w_word;
        r_buf_full <= 1'b1;
      end else if (w_emit) begin
        r_buf_full <= 1'b0;
      end
      if (w_data_word && w_emittable && r_buf_full && !w_emit) r_ovr_err <= 1'b1;
    end
  end

  // Loader word delivery: data, toggle and delivered-word count.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_words <= '0;
    end else if (w_emit) begin
      r_data  <= r_buf;
      r_valid <= ~r_valid;
      r_words <= r_words + ONE_W;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] r_sum;
  logic        r_csum_err;

  // Running mod-2^32 sum of every data word, compared against the trailer.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_sum      <= '0;
      r_csum_err <= 1'b0;
    end else begin
      if (w_data_word) r_sum <= r_sum + w_word;
      if ((r_state == ST_CSUM) && w_word_done && (w_word != r_sum)) r_csum_err <= 1'b1;
    end
  end

  assign checksum_err = r_csum_err;
`else
  assign checksum_err = 1'b0;
`endif

  assign input_data   = r_data;
  assign input_valid  = r_valid;
  assign input_start  = r_start;
  assign words_loaded = r_words;
  assign size_err     = r_size_err;
  assign overrun_err  = r_ovr_err;

endmodule

// File: tb/tb_program_loader_ctrl.sv
// Self-checking bench for program_loader_ctrl: streams are built from random
// words and compared against expectations derived from the stream itself.
module tb_program_loader_ctrl;

  localparam int unsigned W   = 2;
  localparam int unsigned G   = 4;
  localparam int unsigned CAP = 4;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;

  logic [31:0] input_data;
  logic        input_valid, input_start, input_end, busy, done;
  logic [W:0]  words_loaded;
  logic        size_err, overrun_err, checksum_err;

  logic [31:0] d2_data;
  logic        d2_valid, d2_start, d2_end, d2_busy, d2_done;
  logic [W:0]  d2_words;
  logic        d2_size, d2_ovr, d2_cs;

  program_loader_ctrl #(.INST_MEM_WIDTH(W), .TOGGLE_GAP(G)) dut (
    .CLK(CLK), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .input_data(input_data), .input_valid(input_valid), .input_start(input_start),
    .input_end(input_end), .busy(busy), .done(done), .words_loaded(words_loaded),
    .size_err(size_err), .overrun_err(overrun_err), .checksum_err(checksum_err)
  );

  // Slow-gap instance sharing the stream, used to provoke an overrun.
  program_loader_ctrl #(.INST_MEM_WIDTH(W), .TOGGLE_GAP(15)) dut2 (
    .CLK(CLK), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .input_data(d2_data), .input_valid(d2_valid), .input_start(d2_start),
    .input_end(d2_end), .busy(d2_busy), .done(d2_done), .words_loaded(d2_words),
    .size_err(d2_size), .overrun_err(d2_ovr), .checksum_err(d2_cs)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Event monitor: records toggles, start and end, cleared while in reset.
  int          cyc = 0;
  logic        prev_v = 1'b0;
  logic [31:0] got_words[$];
  int          tog_cyc[$];
  int          n_start = 0, n_end = 0, start_cyc = 0, end_cyc = 0;
  logic        overlap = 1'b0;

  always @(negedge CLK) begin
    cyc++;
    if (reset) begin
      prev_v = 1'b0;
      got_words.delete();
      tog_cyc.delete();
      n_start = 0;
      n_end   = 0;
      overlap = 1'b0;
    end else begin
      if (input_valid != prev_v) begin
        got_words.push_back(input_data);
        tog_cyc.push_back(cyc);
        prev_v = input_valid;
      end
      if (input_start) begin n_start++; start_cyc = cyc; end
      if (input_end)   begin n_end++;   end_cyc = cyc;   end
      if (input_start && input_end) overlap = 1'b1;
    end
  end

  logic [31:0] stim[$];

  task automatic do_reset();
    @(negedge CLK);
    reset = 1'b1;
    rx_valid = 1'b0;
    repeat (2) @(negedge CLK);
    reset = 1'b0;
  endtask

  // Called aligned to a negedge; leaves rx_valid high for exactly one edge.
  task automatic send_byte(input logic [7:0] b, input int unsigned sp);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge CLK);
    rx_valid = 1'b0;
    repeat (sp - 1) @(negedge CLK);
  endtask

  task automatic send_word(input logic [31:0] w, input int unsigned lo, input int unsigned hi);
    for (int b = 3; b >= 0; b--) send_byte(w[8*b +: 8], $urandom_range(hi, lo));
  endtask

  task automatic wait_done(input string tag, input bit second);
    for (int i = 0; i < 3000 && !(done && (!second || d2_done)); i++) @(negedge CLK);
    check(tag, {31'b0, done && (!second || d2_done)}, 32'd1);
  endtask

  task automatic run_load(input int unsigned n, input int unsigned lo, input int unsigned hi,
                          input bit bad, input bit second);
    logic [31:0] sum;
    int unsigned n_emit;
    int          last;
    bit          exp_cs;
    do_reset();
    sum = '0;
    send_word(n, lo, hi);
    for (int unsigned i = 0; i < n; i++) begin
      send_word(stim[i], lo, hi);
      sum += stim[i];
    end
    exp_cs = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    if (n != 0) begin
      send_word(sum + {31'b0, bad}, lo, hi);
      exp_cs = bad;
    end
`endif
    wait_done("done", second);
    n_emit = (n < CAP) ? n : CAP;
    check("words_loaded", {29'b0, words_loaded}, n_emit);
    check("toggles", got_words.size(), n_emit);
    for (int i = 0; i < got_words.size() && i < int'(n_emit); i++)
      check("input_data", got_words[i], stim[i]);
    check("size_err", {31'b0, size_err}, {31'b0, n > CAP});
    check("overrun_err", {31'b0, overrun_err}, 32'd0);
    check("checksum_err", {31'b0, checksum_err}, {31'b0, exp_cs});
    check("start_count", n_start, 32'd1);
    check("end_count", n_end, 32'd1);
    check("start_end_overlap", {31'b0, overlap}, 32'd0);
    check("busy_after_done", {31'b0, busy}, 32'd0);
    last = start_cyc;
    foreach (tog_cyc[i]) begin
      check("toggle_spacing_ok", {31'b0, (tog_cyc[i] - last) >= int'(G)}, 32'd1);
      last = tog_cyc[i];
    end
    check("end_spacing_ok", {31'b0, (end_cyc - last) >= int'(G)}, 32'd1);
  endtask

  initial begin
    do_reset();
    check("rst_input_data", input_data, 32'd0);
    check("rst_input_valid", {31'b0, input_valid}, 32'd0);
    check("rst_start_end", {30'b0, input_start, input_end}, 32'd0);
    check("rst_busy_done", {30'b0, busy, done}, 32'd0);
    check("rst_words", {29'b0, words_loaded}, 32'd0);
    check("rst_errs", {29'b0, size_err, overrun_err, checksum_err}, 32'd0);

    // Basic load, bytes spaced 10 cycles.
    stim = '{32'hDEADBEEF, 32'h01020304};
    run_load(2, 10, 10, 1'b0, 1'b0);

    // Back-to-back bytes, N=3; the slow-gap instance must overrun.
    stim = '{$urandom, $urandom, $urandom};
    run_load(3, 1, 1, 1'b0, 1'b1);
    check("slow_overrun", {31'b0, d2_ovr}, 32'd1);
    check("slow_words", {29'b0, d2_words}, 32'd1);
    check("slow_data", d2_data, stim[0]);

    // Empty program.
    stim.delete();
    run_load(0, 2, 6, 1'b0, 1'b0);

    // Oversize: N=6 into capacity 4.
    stim = '{$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    run_load(6, 2, 5, 1'b0, 1'b0);

    // Random loads.
    for (int t = 0; t < 6; t++) begin
      int unsigned n;
      n = $urandom_range(5, 1);
      stim.delete();
      for (int unsigned i = 0; i < n; i++) stim.push_back($urandom);
      run_load(n, 2, 8, 1'b0, 1'b0);
    end

    // Reset mid-load after one delivered word, then a fresh load.
    do_reset();
    stim = '{$urandom, $urandom, $urandom};
    send_word(32'd3, 3, 3);
    send_word(stim[0], 3, 3);
    for (int i = 0; i < 200 && got_words.size() == 0; i++) @(negedge CLK);
    check("midload_toggle", got_words.size(), 32'd1);
    reset = 1'b1;
    @(posedge CLK);
    #1;
    check("mid_rst_data", input_data, 32'd0);
    check("mid_rst_valid", {31'b0, input_valid}, 32'd0);
    check("mid_rst_words", {29'b0, words_loaded}, 32'd0);
    check("mid_rst_flags", {28'b0, busy, done, input_start, input_end}, 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    reset = 1'b0;
    stim = '{$urandom, $urandom};
    run_load(2, 2, 6, 1'b0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    stim = '{32'h00000001, 32'hFFFFFFFF};
    run_load(2, 2, 4, 1'b0, 1'b0);
    run_load(2, 2, 4, 1'b1, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
